muldiv_unit: RTL
================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand/result width in bits (even, >=8).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request to begin an operation with current op/a/b.
REQ-005 SHALL have port op  input  3  RISC-V M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 SHALL have port a  input  WIDTH  rs1 operand (multiplicand/dividend).
REQ-007 SHALL have port b  input  WIDTH  rs2 operand (multiplier/divisor).
REQ-008 SHALL have port flush  input  1  abort any in-flight operation (pipeline flush).
REQ-009 SHALL have port busy  output  1  operation in flight; hazard unit stalls on it.
REQ-010 SHALL have port done  output  1  one-cycle pulse: result valid.
REQ-011 SHALL have port result  output  WIDTH  operation result.

Function
REQ-012 SHALL implement FSM states IDLE, CALC, DONE.
REQ-013 IDLE: start=1 and flush=0 SHALL latch op/a/b and go to CALC, or to DONE directly for a special case (REQ-018/019).
REQ-014 CALC SHALL run exactly WIDTH iterations (radix-2 shift-add multiply / restoring divide on magnitudes), then go to DONE.
REQ-015 DONE SHALL assert done for exactly one cycle and return to IDLE; result SHALL hold its value until the next accepted start.
REQ-016 Latency: normal op SHALL pulse done WIDTH+1 cycles after the start cycle (33 at WIDTH=32); special case SHALL pulse done 1 cycle after.
REQ-017 Signedness: MUL/MULH/DIV/REM both signed; MULHSU a signed, b unsigned; MULHU/DIVU/REMU unsigned. MUL returns low WIDTH bits, MULH* high WIDTH bits of the 2*WIDTH product. Quotient rounds toward zero; remainder takes the dividend's sign.
REQ-018 Divide by zero: quotient SHALL be all-ones, remainder SHALL be a (signed and unsigned).
REQ-019 Signed overflow (a = most-negative, b = -1, DIV/REM): quotient SHALL be a, remainder SHALL be 0.
REQ-020 busy SHALL be 1 in CALC and DONE, 0 in IDLE; start while busy SHALL be ignored.
REQ-021 flush SHALL force IDLE next cycle from any state, suppress done, leave result unchanged; flush with start in the same cycle: flush wins, start ignored.
REQ-022 start in IDLE in the cycle after DONE SHALL be accepted (back-to-back issue, no bubble beyond DONE).

Reset
REQ-023 reset SHALL force IDLE, busy=0, done=0, result=0, internal accumulators to 0 on the next rising edge, regardless of state.
REQ-024 reset mid-operation SHALL discard it; no done pulse SHALL follow.
REQ-025 reset SHALL take priority over flush and start.

Structure
REQ-026 muldiv_pkg SHALL hold the op encoding enum (MD_MUL..MD_REMU) and FSM state enum; the datapath decoder SHALL import it.
REQ-027 One sub-module muldiv_signfix SHALL be used: combinational operand absolute-value/sign extraction per op and final result negation/selection.
REQ-028 Iteration counter SHALL be clog2(WIDTH)+1 bits wide.

Verification (WIDTH=32)
REQ-029 MUL a=7, b=0xFFFFFFFD -> result 0xFFFFFFEB, done exactly 33 cycles after start, busy high throughout.
REQ-030 MULH a=b=0x80000000 -> 0x40000000; MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE; MULHSU a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF.
REQ-031 DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14, REMU -> 2.
REQ-032 DIVU a=5, b=0 -> 0xFFFFFFFF and REMU -> 5, done 1 cycle after start; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0.
REQ-033 MUL started, flush at cycle 10 -> busy=0 next cycle, no done, result unchanged; immediate new start completes normally.
REQ-034 reset at cycle 20 of DIV -> IDLE, result=0, no done; start while busy (cycle 5) ignored, original result returned.

Source files
------------

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - op encoding, FSM states and op-class helpers for muldiv_unit
package muldiv_pkg;

  // RISC-V M-extension funct3 encoding
  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } md_state_e;

  // All divide-class ops share funct3[2]
  function automatic logic md_is_div(input md_op_e op);
    return op[2];
  endfunction

  function automatic logic md_is_rem(input md_op_e op);
    return (op == MD_REM) || (op == MD_REMU);
  endfunction

  // MUL low bits are sign-agnostic, so treating it as signed is harmless
  function automatic logic md_a_signed(input md_op_e op);
    return (op == MD_MUL) || (op == MD_MULH) || (op == MD_MULHSU) ||
           (op == MD_DIV) || (op == MD_REM);
  endfunction

  function automatic logic md_b_signed(input md_op_e op);
    return (op == MD_MUL) || (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// rtl/muldiv_signfix.sv - operand magnitude extraction and final result sign fix-up
module muldiv_signfix
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  md_op_e             i_op,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic [WIDTH-1:0]   o_mag_a,
  output logic [WIDTH-1:0]   o_mag_b,
  output logic               o_neg,
  input  md_op_e             i_res_op,
  input  logic               i_res_neg,
  input  logic [WIDTH-1:0]   i_hi,
  input  logic [WIDTH-1:0]   i_lo,
  output logic [WIDTH-1:0]   o_result
);

  logic                 w_a_neg;
  logic                 w_b_neg;
  logic [2*WIDTH-1:0]   w_prod;
  logic [2*WIDTH-1:0]   w_prod_s;
  logic [WIDTH-1:0]     w_quot_s;
  logic [WIDTH-1:0]     w_rem_s;

  // Most-negative operand negates to itself, which is still the right unsigned magnitude
  assign w_a_neg = md_a_signed(i_op) & i_a[WIDTH-1];
  assign w_b_neg = md_b_signed(i_op) & i_b[WIDTH-1];
  assign o_mag_a = w_a_neg ? -i_a : i_a;
  assign o_mag_b = w_b_neg ? -i_b : i_b;
  // Remainder follows the dividend sign; product and quotient follow the sign XOR
  assign o_neg   = md_is_rem(i_op) ? w_a_neg : (w_a_neg ^ w_b_neg);

  assign w_prod   = {i_hi, i_lo};
  assign w_prod_s = i_res_neg ? -w_prod : w_prod;
  assign w_quot_s = i_res_neg ? -i_lo : i_lo;
  assign w_rem_s  = i_res_neg ? -i_hi : i_hi;

  // Pick the result slice for the latched op
  always_comb begin
    o_result = w_rem_s;
    case (i_res_op)
      MD_MUL:                       o_result = w_prod_s[WIDTH-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: o_result = w_prod_s[2*WIDTH-1:WIDTH];
      MD_DIV, MD_DIVU:              o_result = w_quot_s;
      default:                      o_result = w_rem_s;
    endcase
  end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit with flush and special-case bypass
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int                CNT_W    = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0]  MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  md_state_e          r_state;
  md_state_e          w_state_nxt;
  md_op_e             r_op;
  logic               r_neg;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   r_opnd;
  logic [WIDTH-1:0]   r_result;
  logic [CNT_W-1:0]   r_cnt;

  md_op_e             w_op;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic               w_neg;
  logic [WIDTH-1:0]   w_final;
  logic [WIDTH-1:0]   w_hi_nxt;
  logic [WIDTH-1:0]   w_lo_nxt;
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH:0]     w_div_sh;
  logic [WIDTH:0]     w_div_diff;
  logic               w_accept;
  logic               w_last;
  logic               w_div_zero;
  logic               w_overflow;
  logic               w_special;
  logic [WIDTH-1:0]   w_special_val;

  assign w_op       = md_op_e'(op);
  assign w_accept   = (r_state == ST_IDLE) && start && !flush;
  assign w_last     = (r_cnt == LAST_CNT);
  assign w_div_zero = md_is_div(w_op) && (b == '0);
  assign w_overflow = ((w_op == MD_DIV) || (w_op == MD_REM)) && (a == MOST_NEG) && (b == '1);
  assign w_special  = w_div_zero || w_overflow;
  assign result     = r_result;

  muldiv_signfix #(.WIDTH(WIDTH)) u_signfix (
    .i_op      (w_op),
    .i_a       (a),
    .i_b       (b),
    .o_mag_a   (w_mag_a),
    .o_mag_b   (w_mag_b),
    .o_neg     (w_neg),
    .i_res_op  (r_op),
    .i_res_neg (r_neg),
    .i_hi      (w_hi_nxt),
    .i_lo      (w_lo_nxt),
    .o_result  (w_final)
  );

  // Results for divide-by-zero and signed overflow are known at issue time
  always_comb begin
    w_special_val = '0;
    if (w_div_zero) begin
      w_special_val = md_is_rem(w_op) ? a : '1;
    end else if (w_overflow) begin
      w_special_val = md_is_rem(w_op) ? '0 : a;
    end
  end

  // One iteration: shift-add multiply on {hi,lo}, or restoring divide with hi as partial remainder
  always_comb begin
    w_mul_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);
    w_div_sh   = {r_hi, r_lo[WIDTH-1]};
    w_div_diff = w_div_sh - {1'b0, r_opnd};
    w_hi_nxt   = w_mul_sum[WIDTH:1];
    w_lo_nxt   = {w_mul_sum[0], r_lo[WIDTH-1:1]};
    if (md_is_div(r_op)) begin
      if (!w_div_diff[WIDTH]) begin
        w_hi_nxt = w_div_diff[WIDTH-1:0];
        w_lo_nxt = {r_lo[WIDTH-2:0], 1'b1};
      end else begin
        w_hi_nxt = w_div_sh[WIDTH-1:0];
        w_lo_nxt = {r_lo[WIDTH-2:0], 1'b0};
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and status outputs; flush aborts everything and masks the done pulse
  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start && !flush) begin
          w_state_nxt = w_special ? ST_DONE : ST_CALC;
        end
      end
      ST_CALC: begin
        busy = 1'b1;
        if (flush) begin
          w_state_nxt = ST_IDLE;
        end else if (w_last) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        busy        = 1'b1;
        done        = !flush;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Operand latch, iteration registers and result capture
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op     <= MD_MUL;
      r_neg    <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_opnd   <= '0;
      r_cnt    <= '0;
      r_result <= '0;
    end else if (w_accept) begin
      r_op  <= w_op;
      r_neg <= w_neg;
      r_hi  <= '0;
      r_cnt <= '0;
      if (md_is_div(w_op)) begin
        r_lo   <= w_mag_a;
        r_opnd <= w_mag_b;
      end else begin
        r_lo   <= w_mag_b;
        r_opnd <= w_mag_a;
      end
      if (w_special) begin
        r_result <= w_special_val;
      end
    end else if ((r_state == ST_CALC) && !flush) begin
      r_hi  <= w_hi_nxt;
      r_lo  <= w_lo_nxt;
      r_cnt <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_result <= w_final;
      end
    end
  end

endmodule
